// File: rtl/mdu_mult_seq.sv
// mdu_mult_seq: sequential 32x32 shift-add multiplier for MULT/MULTU.
// It has no adder of its own and drives the shared carry-lookahead adder through the add_* port.
module mdu_mult_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] add_a,
   output logic [WIDTH-1:0] add_b,
   output logic             add_cin,
   input  logic [WIDTH-1:0] add_sum,
   input  logic             add_cout
);
   typedef enum logic [2:0] {IDLE, NEGA, NEGB, MUL, FIXLO, FIXHI, DONE} state_t;
   state_t state, state_n;
   logic [WIDTH-1:0] m, q, p, m_n, q_n, p_n;
   logic [4:0] cnt, cnt_n;
   logic sgn, sgn_n, neg, neg_n, c, c_n;
   assign busy = state != IDLE;
   assign done = state == DONE;
   always_comb begin
      state_n = state;
      m_n = m;
      q_n = q;
      p_n = p;
      cnt_n = cnt;
      sgn_n = sgn;
      neg_n = neg;
      c_n = c;
      add_a = '0;
      add_b = '0;
      add_cin = 1'b0;
      unique case (state)
         IDLE: if (start && !abort) begin
            m_n = op_a;
            q_n = op_b;
            p_n = '0;
            cnt_n = '0;
            c_n = 1'b0;
            sgn_n = is_signed;
            neg_n = is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            state_n = is_signed ? NEGA : MUL;
         end
         NEGA: begin
            add_a = m[WIDTH-1] ? ~m : m;
            add_cin = m[WIDTH-1];
            m_n = add_sum;
            state_n = NEGB;
         end
         NEGB: begin
            add_a = q[WIDTH-1] ? ~q : q;
            add_cin = q[WIDTH-1];
            q_n = add_sum;
            state_n = MUL;
         end
         MUL: begin
            add_a = p;
            add_b = q[0] ? m : '0;
            // carry-out lands in P's MSB so the full 65-bit partial sum shifts right intact
            {p_n, q_n} = {add_cout, add_sum, q[WIDTH-1:1]};
            cnt_n = cnt + 5'd1;
            if (cnt == 5'(WIDTH - 1)) state_n = sgn ? FIXLO : DONE;
         end
         FIXLO: begin
            add_a = neg ? ~q : q;
            add_cin = neg;
            q_n = add_sum;
            c_n = add_cout;
            state_n = FIXHI;
         end
         FIXHI: begin
            add_a = neg ? ~p : p;
            add_cin = neg & c;
            p_n = add_sum;
            state_n = DONE;
         end
         DONE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
      if (abort && state != IDLE) state_n = IDLE;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         m <= '0;
         q <= '0;
         p <= '0;
         cnt <= '0;
         sgn <= 1'b0;
         neg <= 1'b0;
         c <= 1'b0;
         hi <= '0;
         lo <= '0;
      end else begin
         state <= state_n;
         m <= m_n;
         q <= q_n;
         p <= p_n;
         cnt <= cnt_n;
         sgn <= sgn_n;
         neg <= neg_n;
         c <= c_n;
         // hi/lo take the finished product on entry to DONE, so they never show partials
         if (state_n == DONE) begin
            hi <= p_n;
            lo <= q_n;
         end
      end
   end
endmodule

// File: tb/tb_mdu_mult_seq.sv
// tb_mdu_mult_seq: scoreboard bench for mdu_mult_seq with the shared adder modelled here.
// Expected products come from plain 64-bit arithmetic; a negedge monitor pops them on done.
module tb_mdu_mult_seq;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, is_signed = 1'b0;
   logic [31:0] op_a = '0, op_b = '0;
   logic busy, done, add_cin, add_cout;
   logic [31:0] hi, lo, add_a, add_b, add_sum;
   typedef struct {logic [63:0] prod; int due;} exp_t;
   exp_t sb[$];
   exp_t got;
   int cyc = 0, checks = 0, passes = 0;
   logic [63:0] last = '0;

   mdu_mult_seq #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .is_signed(is_signed),
      .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .hi(hi), .lo(lo),
      .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout)
   );

   always #5 clk = ~clk;
   assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + 33'(add_cin);
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endfunction

   function automatic logic [63:0] ref_mul(logic [31:0] a, logic [31:0] b, logic s);
      longint sa = longint'($signed(a));
      longint sb_ = longint'($signed(b));
      return s ? 64'(sa * sb_) : {32'b0, a} * {32'b0, b};
   endfunction

   always @(negedge clk) if (!rst) begin
      if (!busy || done) chk("adder_idle", 64'(add_a) | 64'(add_b) | 64'(add_cin), 64'd0);
      if (done) begin
         if (sb.size() == 0) begin
            checks++;
            $display("FAIL spurious_done: done at cycle %0d, required no done", cyc);
         end else begin
            got = sb.pop_front();
            chk("product", {hi, lo}, got.prod);
            chk("latency", 64'(cyc), 64'(got.due));
            chk("busy_at_done", 64'(busy), 64'd1);
         end
      end
   end

   task automatic wait_idle();
      for (int i = 0; i < 60; i++) begin
         if (!busy) return;
         @(negedge clk);
      end
      checks++;
      $display("FAIL timeout: busy still %0d after 60 cycles, required 0", busy);
   endtask

   task automatic issue(logic [31:0] a, logic [31:0] b, logic s, bit track);
      exp_t e;
      is_signed = s;
      op_a = a;
      op_b = b;
      start = 1'b1;
      if (track) begin
         e.prod = ref_mul(a, b, s);
         e.due = cyc + 1 + (s ? 36 : 32);
         sb.push_back(e);
         last = e.prod;
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_op(logic [31:0] a, logic [31:0] b, logic s);
      issue(a, b, s, 1'b1);
      wait_idle();
   endtask

   function automatic logic [31:0] rnd();
      logic [31:0] corner [5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
      return ($urandom_range(3) == 0) ? corner[$urandom_range(4)] : $urandom;
   endfunction

   initial begin
      repeat (2) @(negedge clk);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_done", 64'(done), 64'd0);
      chk("reset_hilo", {hi, lo}, 64'd0);
      chk("reset_adder", 64'(add_a) | 64'(add_b) | 64'(add_cin), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
      run_op(32'hFFFFFFFF, 32'h00000001, 1'b1);
      run_op(32'h80000000, 32'h80000000, 1'b1);
      run_op(32'hFFFFFFFB, 32'h00000000, 1'b1);
      run_op(32'hFFFFFFFD, 32'h00000007, 1'b1);
      run_op(32'h00000000, 32'h80000000, 1'b1);
      // re-pulsed start with new operands mid-operation must be ignored
      issue(32'd6, 32'd7, 1'b0, 1'b1);
      repeat (3) @(negedge clk);
      issue(32'd99, 32'd123, 1'b1, 1'b0);
      wait_idle();
      run_op(32'd5, 32'd9, 1'b0);
      // abort at MUL cycle 10: no done, hi/lo keep the previous product
      issue(32'h1234, 32'h5678, 1'b0, 1'b0);
      repeat (10) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_hilo", {hi, lo}, last);
      repeat (40) @(negedge clk);
      chk("abort_quiet", 64'(busy), 64'd0);
      // abort together with start in IDLE wins
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      chk("abort_start_idle", 64'(busy), 64'd0);
      // asynchronous reset mid-MUL clears without a clock edge
      issue(32'hDEADBEEF, 32'h12345678, 1'b1, 1'b0);
      repeat (8) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_hilo", {hi, lo}, 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      last = '0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 1500; i++) run_op(rnd(), rnd(), 1'($urandom_range(1)));
      repeat (3) @(negedge clk);
      chk("scoreboard_drain", 64'(sb.size()), 64'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
